// File: rtl/u_uart_pkg.sv
// Shared UART constants and state encodings for the transmitter and receiver.
package u_uart_pkg;

  localparam int WORD_LEN   = 8;
  localparam int OVERSAMPLE = 16;

  // Cell-count thresholds for 16x oversampling: half a bit to mid-start, then one bit minus the sample cycle.
  localparam logic [3:0] CENTER_CNT = 4'd7;
  localparam logic [3:0] WAIT_CNT   = 4'd14;

  typedef enum logic [2:0] {
    r_IDLE   = 3'd0,
    r_CENTER = 3'd1,
    r_WAIT   = 3'd2,
    r_SAMPLE = 3'd3,
    r_STOP   = 3'd4,
    r_HOLD   = 3'd5
  } rec_state_e;

  typedef enum logic [1:0] {
    t_IDLE  = 2'd0,
    t_START = 2'd1,
    t_DATA  = 2'd2,
    t_STOP  = 2'd3
  } xmit_state_e;

endpackage

// File: rtl/u_rx_sync.sv
// Two-flop synchronizer for the serial line; both flops reset to the idle level (1).
module u_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/u_rec.sv
// UART receiver, 8N1 LSB-first, clocked at 16x baud.
// Define U_REC_SYNC_EN to put a 2-flop synchronizer in front of the FSM.
module u_rec
  import u_uart_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_recH,
  output logic [7:0] rec_dataH,
  output logic       rec_readyH,
  output logic       rec_frame_errH,
  output logic       rec_busyH,
  output rec_state_e rec_stateH
);

  logic rx;

`ifdef U_REC_SYNC_EN
  u_rx_sync u_sync (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (uart_recH),
    .q_o   (rx)
  );
`else
  assign rx = uart_recH;
`endif

  rec_state_e state_q, state_d;
  logic [3:0] cell_q, cell_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       ready_q, ready_d;
  logic       err_q, err_d;
  logic       busy_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= r_IDLE;
      cell_q  <= 4'd0;
      bit_q   <= 4'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= (state_d != r_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q + 4'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      r_IDLE: begin
        cell_d = 4'd0;
        bit_d  = 4'd0;
        if (!rx) state_d = r_CENTER;
      end
      r_CENTER: begin
        if (cell_q == CENTER_CNT) begin
          cell_d  = 4'd0;
          state_d = rx ? r_IDLE : r_WAIT;
        end
      end
      r_WAIT: begin
        if (cell_q == WAIT_CNT) begin
          cell_d  = 4'd0;
          state_d = (bit_q == 4'(WORD_LEN)) ? r_STOP : r_SAMPLE;
        end
      end
      r_SAMPLE: begin
        shift_d = {rx, shift_q[7:1]};
        bit_d   = bit_q + 4'd1;
        cell_d  = 4'd0;
        state_d = r_WAIT;
      end
      r_STOP: begin
        cell_d = 4'd0;
        if (rx) begin
          data_d  = shift_q;
          ready_d = 1'b1;
          state_d = r_IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = r_HOLD;
        end
      end
      r_HOLD: begin
        // A held-low line (break) must not look like a fresh start bit.
        cell_d = 4'd0;
        if (rx) state_d = r_IDLE;
      end
      default: begin
        cell_d  = 4'd0;
        bit_d   = 4'd0;
        state_d = r_IDLE;
      end
    endcase
  end

  assign rec_dataH      = data_q;
  assign rec_readyH     = ready_q;
  assign rec_frame_errH = err_q;
  assign rec_busyH      = busy_q;
  assign rec_stateH     = state_q;

endmodule

// File: tb/tb_u_rec.sv
// Directed bench for u_rec: a bit-level serial driver, a pulse monitor and an expected-byte scoreboard.
module tb_u_rec;
  import u_uart_pkg::*;

`ifdef U_REC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       sys_clk;
  logic       sys_rst;
  logic       uart_recH;
  logic [7:0] rec_dataH;
  logic       rec_readyH;
  logic       rec_frame_errH;
  logic       rec_busyH;
  rec_state_e rec_stateH;

  int total;
  int bad;
  int cyc;

  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  int         err_t[$];
  int         exp_err_t[$];

  u_rec dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .uart_recH      (uart_recH),
    .rec_dataH      (rec_dataH),
    .rec_readyH     (rec_readyH),
    .rec_frame_errH (rec_frame_errH),
    .rec_busyH      (rec_busyH),
    .rec_stateH     (rec_stateH)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // A value read at the negedge with cyc==t0+n is the DUT state of cycle T+n+1.
  always @(negedge sys_clk) begin
    if (rec_readyH) begin
      got_q.push_back(rec_dataH);
      got_t.push_back(cyc);
    end
    if (rec_frame_errH) err_t.push_back(cyc);
    if (rec_readyH || rec_frame_errH) begin
      total++;
      assert (!(rec_readyH && rec_frame_errH)) else begin
        bad++;
        $error("FAIL pulse_excl observed=both expected=one at cyc %0d", cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks: always entered and left at a negedge
  task automatic drive_bit(input logic v, input int n);
    uart_recH = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input int p_even, input int p_odd, output int t0);
    logic v;
    t0 = cyc + 1 + LAT;
    for (int j = 0; j < 10; j++) begin
      if (j == 0) v = 1'b0;
      else if (j == 9) v = stop_v;
      else v = d[j-1];
      drive_bit(v, (j % 2 == 0) ? p_even : p_odd);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input int t0);
    exp_q.push_back(d);
    exp_t.push_back(t0 + 152);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
      chk({tag, "_time"}, got_t.pop_front(), exp_t.pop_front());
    end
    chk({tag, "_errcount"}, err_t.size(), exp_err_t.size());
    while (err_t.size() > 0 && exp_err_t.size() > 0)
      chk({tag, "_errtime"}, err_t.pop_front(), exp_err_t.pop_front());
    got_q.delete(); got_t.delete(); exp_q.delete(); exp_t.delete();
    err_t.delete(); exp_err_t.delete();
  endtask

  initial begin
    int t0;
    logic [7:0] c3;
    total = 0;
    bad = 0;
    sys_rst = 1'b1;
    uart_recH = 1'b1;
    @(negedge sys_clk);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    // reset state
    chk("rst_data", rec_dataH, 8'h00);
    chk("rst_ready", rec_readyH, 1'b0);
    chk("rst_err", rec_frame_errH, 1'b0);
    chk("rst_busy", rec_busyH, 1'b0);
    chk("rst_state", rec_stateH, r_IDLE);
    repeat (20) @(negedge sys_clk);

    // single byte at exact timing, pulse at T+153
    send_frame(8'hA5, 1'b1, 16, 16, t0);
    expect_byte(8'hA5, t0);
    repeat (20) @(negedge sys_clk);
    check_sb("single");
    chk("single_hold", rec_dataH, 8'hA5);
    chk("single_busy", rec_busyH, 1'b0);

    // back-to-back frames, as the transmitter would send them
    send_frame(8'h00, 1'b1, 16, 16, t0); expect_byte(8'h00, t0);
    send_frame(8'hFF, 1'b1, 16, 16, t0); expect_byte(8'hFF, t0);
    send_frame(8'h55, 1'b1, 16, 16, t0); expect_byte(8'h55, t0);
    repeat (20) @(negedge sys_clk);
    check_sb("b2b");

    // false start: 4 low cycles, rejected at mid start bit
    t0 = cyc + 1 + LAT;
    drive_bit(1'b0, 4);
    uart_recH = 1'b1;
    wait_until(t0 + 7);
    chk("fs_center", rec_stateH, r_CENTER);
    chk("fs_busy_hi", rec_busyH, 1'b1);
    wait_until(t0 + 8);
    chk("fs_idle", rec_stateH, r_IDLE);
    chk("fs_busy_lo", rec_busyH, 1'b0);
    wait_until(t0 + 60);
    chk("fs_busy_late", rec_busyH, 1'b0);
    check_sb("fs");

    // framing error followed by a break: 16 + 64 low cycles from the stop bit
    send_frame(8'h3C, 1'b0, 16, 16, t0);
    exp_err_t.push_back(t0 + 152);
    wait_until(t0 + 200);
    chk("fe_hold", rec_stateH, r_HOLD);
    chk("fe_busy", rec_busyH, 1'b1);
    chk("fe_data", rec_dataH, 8'h55);
    wait_until(t0 + 223);
    chk("fe_hold_end", rec_stateH, r_HOLD);
    uart_recH = 1'b1;
    @(negedge sys_clk);
    chk("fe_release", rec_stateH, r_IDLE);
    repeat (20) @(negedge sys_clk);
    chk("fe_idle_busy", rec_busyH, 1'b0);
    check_sb("fe");

    // reset during data bit 4 of 8'hC3, then a clean 8'h81
    c3 = 8'hC3;
    drive_bit(1'b0, 16);
    for (int k = 0; k < 4; k++) drive_bit(c3[k], 16);
    uart_recH = c3[4];
    repeat (8) @(negedge sys_clk);
    chk("mr_busy_pre", rec_busyH, 1'b1);
    sys_rst = 1'b1;
    uart_recH = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("mr_state", rec_stateH, r_IDLE);
    chk("mr_data", rec_dataH, 8'h00);
    repeat (30) @(negedge sys_clk);
    chk("mr_busy", rec_busyH, 1'b0);
    send_frame(8'h81, 1'b1, 16, 16, t0);
    expect_byte(8'h81, t0);
    repeat (20) @(negedge sys_clk);
    check_sb("mr");
    chk("mr_final", rec_dataH, 8'h81);

    // baud skew: 17-cycle bits (slow), then alternating 15/16-cycle bits (~3% fast).
    // A uniform 15-cycle bit is 6% fast and drifts past the edge of data bit 6.
    send_frame(8'h96, 1'b1, 17, 17, t0); expect_byte(8'h96, t0);
    send_frame(8'h96, 1'b1, 15, 16, t0); expect_byte(8'h96, t0);
    repeat (20) @(negedge sys_clk);
    check_sb("skew");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
